// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix loader (front end of the 5x5 RREF inverter).
//   MAT_DATA_W / MAT_DIM : default element width and matrix order
//   ELEMS                : elements per frame (DIM*DIM)
//   CNT_W                : width of the element index counter
//   state_t              : loader FSM states (FILL, FULL)
//   idx(row,col)         : row-major flat element index
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int MAT_DATA_W = 32;
    localparam int MAT_DIM    = 5;
    localparam int ELEMS      = MAT_DIM * MAT_DIM;
    localparam int CNT_W      = $clog2(ELEMS);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int idx(input int row, input int col);
        return row * MAT_DIM + col;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// -----------------------------------------------------------------------------
// matrix_bank
// DEPTH x DATA_W register file holding one matrix. Written one element per
// cycle, read as a single flat word (element k at bits [k*DATA_W +: DATA_W]).
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable
//   waddr  in  element index to write
//   wdata  in  element value
//   flat   out whole bank, row-major
// Contents carry no reset; the loader never exposes a bank until all of its
// elements have been rewritten by a complete frame.
// -----------------------------------------------------------------------------
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int DATA_W = MAT_DATA_W,
    parameter int DEPTH  = ELEMS,
    parameter int AW     = CNT_W
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DEPTH*DATA_W-1:0]   flat
);

    for (genvar k = 0; k < DEPTH; k++) begin : g_elem
        logic signed [DATA_W-1:0] elem;

        always_ff @(posedge clk) begin
            if (we && (waddr == AW'(k))) begin
                elem <= wdata;
            end
        end

        assign flat[k*DATA_W +: DATA_W] = elem;
    end

endmodule

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Collects a row-major stream of DIM*DIM elements over valid/ready and presents
// the complete matrix as one flat word, held under valid/ready until consumed.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   element stream handshake (s_ready is registered)
//   s_data, s_last    element value and end-of-frame marker
//   m_valid/m_ready   matrix handshake toward the inverter
//   m_flat            element k at bits [k*DATA_W +: DATA_W], zero when idle
//   err_len           one-cycle pulse when s_last disagrees with the count
// Build option:
//   MATRIX_LOADER_PINGPONG_EN  two banks; one fills while the other is held.
//   Undefined: single bank with strict FILL/FULL alternation.
// -----------------------------------------------------------------------------
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W = MAT_DATA_W,
    parameter int DIM    = MAT_DIM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DIM*DIM*DATA_W-1:0] m_flat,
    output logic                      err_len
);

    localparam int NEL = DIM * DIM;
    localparam int AW  = $clog2(NEL);

    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic          accept;
    logic          at_last;
    logic          complete;
    logic          consume;

    assign accept   = s_valid && s_ready;
    assign at_last  = (cnt == AW'(NEL - 1));
    assign complete = accept && at_last;
    assign consume  = m_valid && m_ready;

    // The element count is authoritative: an early s_last drops the partial
    // frame, a missing s_last on the final element is reported but ignored.
    always_comb begin
        cnt_nxt = cnt;
        if (accept) begin
            if (at_last || s_last) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            err_len <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            err_len <= accept && (s_last != at_last);
        end
    end

`ifdef MATRIX_LOADER_PINGPONG_EN

    // full[b] marks bank b as holding a complete frame. wr_sel and rd_sel both
    // alternate, which keeps delivery in arrival order.
    logic [1:0]              full;
    logic [1:0]              full_nxt;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [NEL*DATA_W-1:0]   flat0;
    logic [NEL*DATA_W-1:0]   flat1;

    assign m_valid = full[rd_sel];

    always_comb begin
        full_nxt = full;
        if (consume) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (complete) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            full    <= full_nxt;
            s_ready <= ~&full_nxt;
            if (consume) begin
                rd_sel <= ~rd_sel;
            end
            if (complete) begin
                wr_sel <= ~wr_sel;
            end
        end
    end

    matrix_bank #(.DATA_W(DATA_W), .DEPTH(NEL), .AW(AW)) u_bank0 (
        .clk   (clk),
        .we    (accept && !wr_sel),
        .waddr (cnt),
        .wdata (s_data),
        .flat  (flat0)
    );

    matrix_bank #(.DATA_W(DATA_W), .DEPTH(NEL), .AW(AW)) u_bank1 (
        .clk   (clk),
        .we    (accept && wr_sel),
        .waddr (cnt),
        .wdata (s_data),
        .flat  (flat1)
    );

    // Gating by m_valid keeps partially written or stale banks invisible.
    assign m_flat = m_valid ? (rd_sel ? flat1 : flat0) : '0;

`else

    state_t                  state;
    state_t                  state_nxt;
    logic                    s_ready_nxt;
    logic                    m_valid_nxt;
    logic [NEL*DATA_W-1:0]   bank_flat;

    always_comb begin
        state_nxt   = state;
        s_ready_nxt = s_ready;
        m_valid_nxt = m_valid;
        case (state)
            FILL: begin
                s_ready_nxt = 1'b1;
                m_valid_nxt = 1'b0;
                if (complete) begin
                    state_nxt   = FULL;
                    s_ready_nxt = 1'b0;
                    m_valid_nxt = 1'b1;
                end
            end
            FULL: begin
                s_ready_nxt = 1'b0;
                m_valid_nxt = 1'b1;
                if (m_ready) begin
                    state_nxt   = FILL;
                    s_ready_nxt = 1'b1;
                    m_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_ready <= s_ready_nxt;
            m_valid <= m_valid_nxt;
        end
    end

    matrix_bank #(.DATA_W(DATA_W), .DEPTH(NEL), .AW(AW)) u_bank0 (
        .clk   (clk),
        .we    (accept),
        .waddr (cnt),
        .wdata (s_data),
        .flat  (bank_flat)
    );

    // The bank is rewritten during FILL; only a completed frame is shown.
    assign m_flat = m_valid ? bank_flat : '0;

`endif

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
// Self-checking bench for matrix_loader. A negedge monitor models the loader's
// element count, pushes each completed frame into a scoreboard queue and pops
// it when the DUT hands the matrix over. Honors MATRIX_LOADER_PINGPONG_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_loader;
    import matrix_pkg::*;

    localparam int W  = MAT_DATA_W;
    localparam int FW = ELEMS * MAT_DATA_W;
`ifdef MATRIX_LOADER_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [FW-1:0] m_flat;
    logic          err_len;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] cur_frame;
    int            mdl_cnt = 0;
    logic          pend_err = 1'b0;
    logic          prev_hold = 1'b0;
    logic [FW-1:0] prev_flat = '0;
    logic          fresh = 1'b1;
    logic          t6_done = 1'b0;

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_flat  (m_flat),
        .err_len (err_len)
    );

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: values at negedge describe the state after the last
    // rising edge and the handshakes that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            mdl_cnt   = 0;
            pend_err  = 1'b0;
            prev_hold = 1'b0;
            fresh     = 1'b1;
        end else begin
            check("err_len", err_len, pend_err);
            check("m_valid", m_valid, sb_q.size() != 0);
            if (!fresh) check("s_ready", s_ready, sb_q.size() < NBANK);
            fresh = 1'b0;
            if (m_valid && prev_hold) check("hold_stable", m_flat, prev_flat);
            if (m_valid && m_ready && sb_q.size() != 0) check("frame", m_flat, sb_q.pop_front());
            pend_err = 1'b0;
            if (s_valid && s_ready) begin
                cur_frame[mdl_cnt*W +: W] = s_data;
                if (mdl_cnt == ELEMS - 1) begin
                    sb_q.push_back(cur_frame);
                    pend_err = !s_last;
                    mdl_cnt  = 0;
                end else if (s_last) begin
                    pend_err = 1'b1;
                    mdl_cnt  = 0;
                end else begin
                    mdl_cnt++;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_flat = m_flat;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        logic acc;
        int   b;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        acc = 1'b0;
        b   = 0;
        while (!acc && b < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            b++;
        end
        if (!acc) check("accept_timeout", acc, 1);
    endtask

    // last_at: 1-based beat carrying s_last, 0 for none.
    task automatic send_frame(input logic [W-1:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            send_beat(base + W'(i), (i + 1) == last_at);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        m_ready = 1'b1;
        while (sb_q.size() != 0 && b < 200) begin
            step();
            b++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        // Reset state
        step();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_flat", m_flat, 0);
        check("rst_err_len", err_len, 0);
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_rst", s_ready, 1);

        // 1: basic frame, latency and single-cycle consume
        m_ready = 1'b1;
        send_frame(32'd1, 25, 25);
        check("t1_valid", m_valid, 1);
        check("t1_elem0", m_flat[idx(0, 0)*W +: W], 32'd1);
        check("t1_elem24", m_flat[idx(4, 4)*W +: W], 32'd25);
        step();
        check("t1_consumed", m_valid, 0);

        // 2: held frame under backpressure
        m_ready = 1'b0;
        send_frame(32'd100, 25, 25);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_valid", m_valid, 1);
            check("t2_elem7", m_flat[idx(1, 2)*W +: W], 32'd107);
            if (NBANK == 1) check("t2_s_ready", s_ready, 0);
        end
        drain();

        // 3: early s_last, then a clean frame
        send_frame(32'd200, 7, 7);
        check("t3_err", err_len, 1);
        check("t3_no_valid", m_valid, 0);
        step();
        check("t3_err_clear", err_len, 0);
        send_frame(32'd300, 25, 25);
        drain();

        // 4: missing s_last on the final beat, next frame starts at index 0
        m_ready = 1'b0;
        send_frame(32'd400, 25, 0);
        check("t4_err", err_len, 1);
        check("t4_valid", m_valid, 1);
        drain();
        send_frame(32'd500, 25, 25);
        drain();

        // 5: reset mid-frame
        send_frame(32'd600, 12, 0);
        rst_n = 1'b0;
        #1;
        check("t5_s_ready", s_ready, 0);
        check("t5_m_valid", m_valid, 0);
        check("t5_m_flat", m_flat, 0);
        check("t5_err_len", err_len, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        send_frame(32'd700, 25, 25);
        drain();

        // 6: back-to-back frames with toggling m_ready
        m_ready = 1'b0;
        fork
            begin
                send_frame(32'h8000_0000, 25, 25);
                send_frame(32'hFFFF_FFF0, 25, 25);
                send_frame(32'd1000, 25, 25);
                send_frame(32'd2000, 25, 25);
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    m_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain();
        step();
        check("end_idle", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
